// File: rtl/game_sequencer_if.sv
// game_sequencer_if: groups the event inputs and display/control outputs of
// the game-flow controller. The sequencer uses the slave modport. Whatever
// drives its inputs (the game top or a bench) uses the master modport.
interface game_sequencer_if;
    // Inputs to the sequencer
    logic       vsync;
    logic       start;
    logic       hit_alien;
    logic       cannon_hit;
    logic       aliens_cleared;
    logic       aliens_landed;
    // Outputs from the sequencer
    logic [2:0] state;
    logic [1:0] lives;
    logic [7:0] score;
    logic       play_en;
    logic       wave_reset;
    logic       respawn;
    logic       blink;

    modport master (
        output vsync, start, hit_alien, cannon_hit, aliens_cleared, aliens_landed,
        input  state, lives, score, play_en, wave_reset, respawn, blink
    );

    modport slave (
        input  vsync, start, hit_alien, cannon_hit, aliens_cleared, aliens_landed,
        output state, lives, score, play_en, wave_reset, respawn, blink
    );
endinterface

// File: rtl/game_sequencer.sv
// game_sequencer: game-flow controller for the invaders game.
// It sequences the attract, play, death, wave-clear and game-over phases.
// Every timer counts frames, and one frame is one vsync rising edge.
// The block owns lives and the two-digit BCD score. It gates ship and laser
// control through play_en and issues wave_reset and respawn pulses.
// All outputs are registered. Everything runs in the pixel clock domain.
module game_sequencer #(
    parameter logic [1:0] LIVES_INIT   = 2'd3,
    parameter logic [7:0] POINTS       = 8'h01,
    parameter logic [7:0] DEATH_FRAMES = 8'd120,
    parameter logic [7:0] WAVE_FRAMES  = 8'd60,
    parameter logic [7:0] OVER_FRAMES  = 8'd180
) (
    input  logic            clk,
    input  logic            reset,
    game_sequencer_if.slave bus
);

    localparam logic [2:0] ST_ATTRACT    = 3'd0;
    localparam logic [2:0] ST_PLAYING    = 3'd1;
    localparam logic [2:0] ST_DYING      = 3'd2;
    localparam logic [2:0] ST_WAVE_CLEAR = 3'd3;
    localparam logic [2:0] ST_GAME_OVER  = 3'd4;

    // Edge-detect registers
    logic       r_vsync_q;
    logic       r_start_q;

    // Architectural state and registered outputs
    logic [2:0] r_state;
    logic [1:0] r_lives;
    logic [7:0] r_score;
    logic [7:0] r_timer;
    logic [2:0] r_blink_cnt;
    logic       r_blink;
    logic       r_play_en;
    logic       r_wave_reset;
    logic       r_respawn;

    // Next-state values
    logic [2:0] w_state_nx;
    logic [1:0] w_lives_nx;
    logic [7:0] w_score_nx;
    logic [7:0] w_timer_nx;
    logic [2:0] w_blink_cnt_nx;
    logic       w_blink_nx;
    logic       w_wave_reset_nx;
    logic       w_respawn_nx;

    // Derived events
    logic       w_tick;
    logic       w_start_edge;
    logic       w_timer_done;

    // BCD adder
    logic [4:0] w_units_sum;
    logic       w_carry;
    logic [3:0] w_units_adj;
    logic [4:0] w_tens_sum;
    logic [7:0] w_score_inc;

    assign w_tick       = bus.vsync & ~r_vsync_q;
    assign w_start_edge = bus.start & ~r_start_q;
    // The timer is done on the tick that takes it from 1 to 0. A stray 0 also
    // counts as done, so that a timed phase can never hang.
    assign w_timer_done = w_tick && (r_timer <= 8'd1);

    // Saturating two-digit BCD add of POINTS to the current score
    assign w_units_sum = {1'b0, r_score[3:0]} + {1'b0, POINTS[3:0]};
    assign w_carry     = (w_units_sum > 5'd9);
    assign w_units_adj = w_carry ? 4'(w_units_sum - 5'd10) : w_units_sum[3:0];
    assign w_tens_sum  = {1'b0, r_score[7:4]} + {1'b0, POINTS[7:4]} + {4'd0, w_carry};
    assign w_score_inc = (w_tens_sum > 5'd9) ? 8'h99 : {w_tens_sum[3:0], w_units_adj};

    // Next-state logic for the phase FSM, lives, score, frame timer and blink
    always_comb begin
        // NOTE: every variable gets a default before the case so that no path
        // leaves it unassigned; an unassigned path would infer a latch.
        w_state_nx      = r_state;
        w_lives_nx      = r_lives;
        w_score_nx      = r_score;
        w_timer_nx      = r_timer;
        w_blink_cnt_nx  = r_blink_cnt;
        w_blink_nx      = r_blink;
        w_wave_reset_nx = 1'b0;
        w_respawn_nx    = 1'b0;

        case (r_state)
            ST_ATTRACT: begin
                if (w_start_edge) begin
                    w_score_nx      = 8'h00;
                    w_lives_nx      = LIVES_INIT;
                    w_wave_reset_nx = 1'b1;
                    w_state_nx      = ST_PLAYING;
                end
            end

            ST_PLAYING: begin
                // A hit scores even if a phase change happens in the same cycle
                if (bus.hit_alien) begin
                    w_score_nx = w_score_inc;
                end
                if (bus.aliens_landed) begin
                    w_lives_nx = 2'd0;
                    w_timer_nx = OVER_FRAMES;
                    w_state_nx = ST_GAME_OVER;
                end else if (bus.cannon_hit) begin
                    if (r_lives <= 2'd1) begin
                        w_lives_nx = 2'd0;
                        w_timer_nx = OVER_FRAMES;
                        w_state_nx = ST_GAME_OVER;
                    end else begin
                        w_lives_nx     = r_lives - 2'd1;
                        w_timer_nx     = DEATH_FRAMES;
                        w_blink_nx     = 1'b1;
                        w_blink_cnt_nx = 3'd0;
                        w_state_nx     = ST_DYING;
                    end
                end else if (bus.aliens_cleared) begin
                    w_timer_nx = WAVE_FRAMES;
                    w_state_nx = ST_WAVE_CLEAR;
                end
            end

            ST_DYING: begin
                if (w_timer_done) begin
                    w_timer_nx   = 8'd0;
                    w_blink_nx   = 1'b0;
                    w_respawn_nx = 1'b1;
                    w_state_nx   = ST_PLAYING;
                end else if (w_tick) begin
                    w_timer_nx     = r_timer - 8'd1;
                    w_blink_cnt_nx = r_blink_cnt + 3'd1;
                    // The count wraps every 8 ticks, and blink toggles on the wrap
                    if (r_blink_cnt == 3'd7) begin
                        w_blink_nx = ~r_blink;
                    end
                end
            end

            ST_WAVE_CLEAR: begin
                if (w_timer_done) begin
                    w_timer_nx      = 8'd0;
                    w_wave_reset_nx = 1'b1;
                    w_respawn_nx    = 1'b1;
                    w_state_nx      = ST_PLAYING;
                end else if (w_tick) begin
                    w_timer_nx = r_timer - 8'd1;
                end
            end

            ST_GAME_OVER: begin
                w_lives_nx = 2'd0;
                if (w_timer_done) begin
                    w_timer_nx = 8'd0;
                    w_lives_nx = LIVES_INIT;
                    w_state_nx = ST_ATTRACT;
                end else if (w_tick) begin
                    w_timer_nx = r_timer - 8'd1;
                end
            end

            default: begin
                w_state_nx = ST_ATTRACT;
                w_timer_nx = 8'd0;
                w_blink_nx = 1'b0;
            end
        endcase
    end

    // State and output registers, with asynchronous reset to the attract phase
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vsync_q    <= 1'b0;
            r_start_q    <= 1'b0;
            r_state      <= ST_ATTRACT;
            r_lives      <= LIVES_INIT;
            r_score      <= 8'h00;
            r_timer      <= 8'd0;
            r_blink_cnt  <= 3'd0;
            r_blink      <= 1'b0;
            r_play_en    <= 1'b0;
            r_wave_reset <= 1'b0;
            r_respawn    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register sample the
            // pre-edge values, independent of statement order.
            r_vsync_q    <= bus.vsync;
            r_start_q    <= bus.start;
            r_state      <= w_state_nx;
            r_lives      <= w_lives_nx;
            r_score      <= w_score_nx;
            r_timer      <= w_timer_nx;
            r_blink_cnt  <= w_blink_cnt_nx;
            r_blink      <= w_blink_nx;
            r_play_en    <= (w_state_nx == ST_PLAYING);
            r_wave_reset <= w_wave_reset_nx;
            r_respawn    <= w_respawn_nx;
        end
    end

    assign bus.state      = r_state;
    assign bus.lives      = r_lives;
    assign bus.score      = r_score;
    assign bus.play_en    = r_play_en;
    assign bus.wave_reset = r_wave_reset;
    assign bus.respawn    = r_respawn;
    assign bus.blink      = r_blink;

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: self-checking bench for game_sequencer.
// The bench models the score as a decimal integer. Each hit pushes its
// expected BCD score to a queue, and the entry is popped and compared once
// the DUT has registered the hit.
module tb_game_sequencer;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   m_score;
    logic [7:0] sb_q[$];

    game_sequencer_if bus();

    game_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1);
    end

    function automatic logic [7:0] to_bcd(input int d);
        return {4'(d / 10), 4'(d % 10)};
    endfunction

    // One clock, with the DUT outputs settled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One frame: the vsync rising edge is sampled on the first clock.
    // The pulses and blink seen right after that tick are returned.
    task automatic frame(output logic o_resp, output logic o_wr, output logic o_blink);
        bus.vsync = 1'b1;
        step();
        o_resp  = bus.respawn;
        o_wr    = bus.wave_reset;
        o_blink = bus.blink;
        bus.vsync = 1'b0;
        step();
    endtask

    // n hit pulses. The model score is pushed before each hit and popped after it.
    task automatic hits(input int n);
        logic [7:0] exp_s;
        for (int i = 0; i < n; i++) begin
            bus.hit_alien = 1'b1;
            m_score = (m_score >= 99) ? 99 : m_score + 1;
            sb_q.push_back(to_bcd(m_score));
            step();
            bus.hit_alien = 1'b0;
            n_checks++;
            if (sb_q.size() == 0) begin
                n_errors++;
                $display("FAIL hit_scoreboard: queue empty, score %h", bus.score);
            end else begin
                exp_s = sb_q.pop_front();
                if (bus.score !== exp_s) begin
                    n_errors++;
                    $display("FAIL hit_score: got %h expected %h", bus.score, exp_s);
                end
            end
        end
    endtask

    // Wait up to 130 frames for the respawn that ends a DYING phase
    task automatic wait_respawn(input string tag);
        logic r, w, b, seen;
        seen = 1'b0;
        for (int k = 0; k < 130 && !seen; k++) begin
            frame(r, w, b);
            if (r) seen = 1'b1;
        end
        n_checks++;
        if (!seen || bus.state !== 3'd1) begin
            n_errors++;
            $display("FAIL %s_respawn: seen %0b state %0d expected seen 1 state 1", tag, seen, bus.state);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.vsync = 0; bus.start = 0; bus.hit_alien = 0;
        bus.cannon_hit = 0; bus.aliens_cleared = 0; bus.aliens_landed = 0;
        repeat (3) step();
        n_checks++;
        if ({bus.state, bus.lives, bus.score, bus.play_en, bus.wave_reset, bus.respawn, bus.blink}
            !== {3'd0, 2'd3, 8'h00, 4'b0000}) begin
            n_errors++;
            $display("FAIL reset_values: state %0d lives %0d score %h pe %0b wr %0b rs %0b bl %0b expected 0 3 00 0 0 0 0",
                     bus.state, bus.lives, bus.score, bus.play_en, bus.wave_reset, bus.respawn, bus.blink);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_start_edge();
        int wr_seen;
        bus.start = 1'b1;
        m_score = 0;
        step();
        n_checks++;
        if ({bus.state, bus.lives, bus.score, bus.play_en, bus.wave_reset} !== {3'd1, 2'd3, 8'h00, 1'b1, 1'b1}) begin
            n_errors++;
            $display("FAIL start_enter: state %0d lives %0d score %h pe %0b wr %0b expected 1 3 00 1 1",
                     bus.state, bus.lives, bus.score, bus.play_en, bus.wave_reset);
        end
        step();
        n_checks++;
        if (bus.wave_reset !== 1'b0) begin
            n_errors++;
            $display("FAIL start_wr_width: got %0b expected 0", bus.wave_reset);
        end
        wr_seen = 0;
        repeat (100) begin
            step();
            if (bus.wave_reset) wr_seen++;
        end
        n_checks++;
        if (wr_seen != 0 || bus.state !== 3'd1) begin
            n_errors++;
            $display("FAIL start_held: extra pulses %0d state %0d expected 0 1", wr_seen, bus.state);
        end
        bus.start = 1'b0;
        step();
    endtask

    task automatic test_scoring();
        hits(12);
        n_checks++;
        if (bus.score !== 8'h12) begin
            n_errors++;
            $display("FAIL score_12: got %h expected 12", bus.score);
        end
        hits(86);
        n_checks++;
        if (bus.score !== 8'h98) begin
            n_errors++;
            $display("FAIL score_98: got %h expected 98", bus.score);
        end
        hits(3);
        n_checks++;
        if (bus.score !== 8'h99 || bus.state !== 3'd1) begin
            n_errors++;
            $display("FAIL score_sat: score %h state %0d expected 99 1", bus.score, bus.state);
        end
    endtask

    task automatic test_dying();
        logic r, w, b;
        int   resp_cnt;
        logic exp_b;
        bus.cannon_hit = 1'b1;
        step();
        bus.cannon_hit = 1'b0;
        n_checks++;
        if ({bus.state, bus.lives, bus.play_en, bus.blink} !== {3'd2, 2'd2, 1'b0, 1'b1}) begin
            n_errors++;
            $display("FAIL dying_enter: state %0d lives %0d pe %0b blink %0b expected 2 2 0 1",
                     bus.state, bus.lives, bus.play_en, bus.blink);
        end
        resp_cnt = 0;
        for (int k = 1; k <= 120; k++) begin
            frame(r, w, b);
            if (r) resp_cnt++;
            if (k < 120) begin
                exp_b = ((k / 8) % 2 == 0);
                n_checks++;
                if (b !== exp_b) begin
                    n_errors++;
                    $display("FAIL dying_blink frame %0d: got %0b expected %0b", k, b, exp_b);
                end
            end else begin
                n_checks++;
                if (r !== 1'b1) begin
                    n_errors++;
                    $display("FAIL dying_respawn_frame: got %0b expected 1", r);
                end
            end
        end
        n_checks++;
        if (resp_cnt != 1 || {bus.state, bus.lives, bus.play_en, bus.blink} !== {3'd1, 2'd2, 1'b1, 1'b0}) begin
            n_errors++;
            $display("FAIL dying_exit: respawns %0d state %0d lives %0d pe %0b blink %0b expected 1 1 2 1 0",
                     resp_cnt, bus.state, bus.lives, bus.play_en, bus.blink);
        end
    endtask

    task automatic test_wave_clear();
        logic r, w, b;
        int   r_cnt, w_cnt;
        bus.aliens_cleared = 1'b1;
        step();
        bus.aliens_cleared = 1'b0;
        n_checks++;
        if (bus.state !== 3'd3 || bus.play_en !== 1'b0) begin
            n_errors++;
            $display("FAIL wave_enter: state %0d pe %0b expected 3 0", bus.state, bus.play_en);
        end
        r_cnt = 0; w_cnt = 0;
        for (int k = 1; k <= 60; k++) begin
            frame(r, w, b);
            if (r) r_cnt++;
            if (w) w_cnt++;
            if (k == 60) begin
                n_checks++;
                if (!(r && w)) begin
                    n_errors++;
                    $display("FAIL wave_pulses_together: respawn %0b wave_reset %0b expected 1 1", r, w);
                end
            end
        end
        n_checks++;
        if (r_cnt != 1 || w_cnt != 1 || {bus.state, bus.lives, bus.score, bus.play_en} !== {3'd1, 2'd2, 8'h99, 1'b1}) begin
            n_errors++;
            $display("FAIL wave_exit: resp %0d wr %0d state %0d lives %0d score %h pe %0b expected 1 1 1 2 99 1",
                     r_cnt, w_cnt, bus.state, bus.lives, bus.score, bus.play_en);
        end
    endtask

    task automatic test_async_reset();
        logic r, w, b;
        bus.aliens_cleared = 1'b1;
        step();
        bus.aliens_cleared = 1'b0;
        repeat (10) frame(r, w, b);
        n_checks++;
        if (bus.state !== 3'd3) begin
            n_errors++;
            $display("FAIL areset_pre: state %0d expected 3", bus.state);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({bus.state, bus.lives, bus.score, bus.play_en, bus.wave_reset, bus.respawn, bus.blink}
            !== {3'd0, 2'd3, 8'h00, 4'b0000}) begin
            n_errors++;
            $display("FAIL areset_values: state %0d lives %0d score %h pe %0b wr %0b rs %0b bl %0b expected 0 3 00 0 0 0 0",
                     bus.state, bus.lives, bus.score, bus.play_en, bus.wave_reset, bus.respawn, bus.blink);
        end
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_priority();
        logic [7:0] exp_s;
        bus.start = 1'b1;
        m_score = 0;
        step();
        bus.start = 1'b0;
        hits(5);
        bus.cannon_hit = 1'b1; bus.aliens_cleared = 1'b1; bus.hit_alien = 1'b1;
        m_score = m_score + 1;
        sb_q.push_back(to_bcd(m_score));
        step();
        bus.cannon_hit = 1'b0; bus.aliens_cleared = 1'b0; bus.hit_alien = 1'b0;
        exp_s = (sb_q.size() != 0) ? sb_q.pop_front() : 8'hxx;
        n_checks++;
        if ({bus.state, bus.lives, bus.score} !== {3'd2, 2'd2, exp_s} || bus.score !== 8'h06) begin
            n_errors++;
            $display("FAIL prio_combined: state %0d lives %0d score %h expected 2 2 06", bus.state, bus.lives, bus.score);
        end
        wait_respawn("prio_first");
        bus.cannon_hit = 1'b1;
        step();
        bus.cannon_hit = 1'b0;
        n_checks++;
        if (bus.state !== 3'd2 || bus.lives !== 2'd1) begin
            n_errors++;
            $display("FAIL prio_second_hit: state %0d lives %0d expected 2 1", bus.state, bus.lives);
        end
        wait_respawn("prio_second");
        bus.cannon_hit = 1'b1;
        step();
        bus.cannon_hit = 1'b0;
        n_checks++;
        if ({bus.state, bus.lives, bus.play_en} !== {3'd4, 2'd0, 1'b0}) begin
            n_errors++;
            $display("FAIL third_hit: state %0d lives %0d pe %0b expected 4 0 0", bus.state, bus.lives, bus.play_en);
        end
    endtask

    task automatic test_game_over();
        logic r, w, b;
        bus.start = 1'b1;
        step();
        n_checks++;
        if (bus.state !== 3'd4 || bus.wave_reset !== 1'b0) begin
            n_errors++;
            $display("FAIL over_start_ignored: state %0d wr %0b expected 4 0", bus.state, bus.wave_reset);
        end
        bus.start = 1'b0;
        repeat (179) frame(r, w, b);
        n_checks++;
        if (bus.state !== 3'd4 || bus.lives !== 2'd0) begin
            n_errors++;
            $display("FAIL over_hold: state %0d lives %0d expected 4 0", bus.state, bus.lives);
        end
        frame(r, w, b);
        n_checks++;
        if ({bus.state, bus.lives, bus.score, bus.play_en} !== {3'd0, 2'd3, 8'h06, 1'b0}) begin
            n_errors++;
            $display("FAIL over_exit: state %0d lives %0d score %h pe %0b expected 0 3 06 0",
                     bus.state, bus.lives, bus.score, bus.play_en);
        end
        bus.hit_alien = 1'b1; bus.cannon_hit = 1'b1;
        step();
        bus.hit_alien = 1'b0; bus.cannon_hit = 1'b0;
        n_checks++;
        if (bus.state !== 3'd0 || bus.score !== 8'h06) begin
            n_errors++;
            $display("FAIL attract_ignore: state %0d score %h expected 0 06", bus.state, bus.score);
        end
    endtask

    task automatic test_landed();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        n_checks++;
        if (bus.state !== 3'd1 || bus.score !== 8'h00 || bus.lives !== 2'd3) begin
            n_errors++;
            $display("FAIL landed_start: state %0d score %h lives %0d expected 1 00 3", bus.state, bus.score, bus.lives);
        end
        bus.aliens_landed = 1'b1; bus.cannon_hit = 1'b1;
        step();
        bus.aliens_landed = 1'b0; bus.cannon_hit = 1'b0;
        n_checks++;
        if (bus.state !== 3'd4 || bus.lives !== 2'd0) begin
            n_errors++;
            $display("FAIL landed_prio: state %0d lives %0d expected 4 0", bus.state, bus.lives);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_score  = 0;
        test_reset();
        test_start_edge();
        test_scoring();
        test_dying();
        test_wave_clear();
        test_async_reset();
        test_priority();
        test_game_over();
        test_landed();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Top-level game-flow controller for the invaders game.
- Sequences attract, play, death, wave-clear and game-over phases, frame-timed from the VGA vsync.
- Owns lives and score. Drives the hud lives/score inputs, gates ship and laser control, and issues wave/respawn pulses to the alien formation and cannon.
- Runs entirely in the pixel clock domain.

Parameters:
- LIVES_INIT, 3, lives loaded at game start (1..3).
- POINTS, 8'h01, BCD points added per alien hit.
- DEATH_FRAMES, 120, frames spent in DYING before respawn (1..255).
- WAVE_FRAMES, 60, frames spent in WAVE_CLEAR before the next wave (1..255).
- OVER_FRAMES, 180, frames spent in GAME_OVER before returning to ATTRACT (1..255).

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous active-high reset
- vsync  in  1  vsync from hvsync_generator, synchronous to clk
- start  in  1  start/fire button level (btn_u)
- hit_alien  in  1  1-cycle pulse, laser destroyed an alien
- cannon_hit  in  1  1-cycle pulse, cannon struck by a bomb
- aliens_cleared  in  1  1-cycle pulse, last alien destroyed
- aliens_landed  in  1  1-cycle pulse, formation reached cannon row
- state  out  3  0 ATTRACT, 1 PLAYING, 2 DYING, 3 WAVE_CLEAR, 4 GAME_OVER
- lives  out  2  remaining lives
- score  out  8  two-digit BCD score {tens, units}
- play_en  out  1  high only in PLAYING; gates ship movement and shooting
- wave_reset  out  1  1-cycle pulse, reload formation and clear laser
- respawn  out  1  1-cycle pulse, recentre cannon
- blink  out  1  cannon blink during DYING

Behaviour:
- Reset values:
  - state = ATTRACT, lives = LIVES_INIT, score = 0.
  - play_en, wave_reset, respawn and blink = 0.
  - Frame timer = 0. vsync and start edge registers = 0.
- Frame tick: 1-cycle internal pulse on the vsync rising edge (registered previous value). Every timer counts frame ticks only.
- Start edge: 1-cycle internal pulse on the start rising edge. A held button produces exactly one edge.
- All outputs are registered. A transition is taken on the cycle the event is sampled, and the outputs reflect it on the next cycle.
- ATTRACT:
  - On start edge: score = 0, lives = LIVES_INIT, wave_reset pulse, go to PLAYING.
  - All other inputs are ignored.
- PLAYING (play_en = 1):
  - hit_alien: score = BCD(score + POINTS), saturating at 8'h99.
  - Scoring is applied in the same cycle as any simultaneous transition event.
  - Event priority: aliens_landed > cannon_hit > aliens_cleared.
  - aliens_landed: lives = 0, go to GAME_OVER, timer loaded with OVER_FRAMES.
  - cannon_hit with lives == 1: lives = 0, go to GAME_OVER, timer loaded with OVER_FRAMES.
  - cannon_hit with lives > 1: lives decrements, go to DYING, timer loaded with DEATH_FRAMES.
  - aliens_cleared: go to WAVE_CLEAR, timer loaded with WAVE_FRAMES.
- DYING:
  - play_en = 0. blink toggles every 8 frame ticks, starting from 1 on entry.
  - Each frame tick decrements the timer.
  - On the tick where the timer reaches 0: respawn pulse, blink = 0, go to PLAYING.
  - hit_alien, cannon_hit and aliens_* are ignored.
- WAVE_CLEAR:
  - play_en = 0. Each frame tick decrements the timer.
  - On reaching 0: wave_reset pulse and respawn pulse in the same cycle, go to PLAYING.
  - Lives and score are held.
- GAME_OVER:
  - play_en = 0. lives = 0. Score is held for display.
  - Start edges are ignored.
  - On the timer reaching 0: go to ATTRACT, lives = LIVES_INIT for display. Score is kept until the next start.
- BCD add:
  - Units digit: sum > 9 → subtract 10 and carry.
  - Tens digit: sum > 9 → result forced to 8'h99.
- Illegal state encodings recover to ATTRACT on the next clk.
- Reset asserted mid-game forces all reset values immediately (asynchronous). Pulses in flight are dropped.

Test Plan:
- Reset, then a start edge → next cycle state = 1, lives = 3, score = 0, play_en = 1; wave_reset high for exactly 1 cycle. Holding start for 100 cycles gives no second pulse.
- In PLAYING, 12 hit_alien pulses → score = 8'h12. Preload 8'h98, then 3 hits → 8'h99, held at 8'h99.
- cannon_hit at lives = 3 → state = 2, lives = 2, play_en = 0. After 120 vsync rising edges, respawn pulses once and state = 1. blink is observed toggling every 8 frames while in DYING.
- Same-cycle cannon_hit + aliens_cleared + hit_alien at score 8'h05 → state = 2 (DYING), score = 8'h06. Same-cycle aliens_landed + cannon_hit → state = 4, lives = 0.
- Third cannon_hit → state = 4. A start edge during GAME_OVER is ignored. After 180 frames → state = 0, lives = 3, score retained.
- aliens_cleared → state = 3. After 60 frames, wave_reset and respawn pulse together and state = 1. Asserting reset mid-WAVE_CLEAR → all outputs return to reset values without waiting for a clk edge.
